// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared types and reset defaults for param_wave_gen.
//   mode_e        : waveform selector (square / triangle / saw up / saw down)
//   default_step  : reset phase step, one LSB of the output phase per cycle
//   default_duty  : reset square threshold, 50 % duty
// The {mode, step, duty} config struct is declared inside param_wave_gen,
// because its field widths follow that module's WIDTH/ACC_W parameters.
package wavegen_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE   = 2'd0,
        MODE_TRIANGLE = 2'd1,
        MODE_SAW_UP   = 2'd2,
        MODE_SAW_DOWN = 2'd3
    } mode_e;

    function automatic int default_step(input int width, input int acc_w);
        return 1 << (acc_w - width);
    endfunction

    function automatic int default_duty(input int width);
        return 1 << (width - 1);
    endfunction

endpackage

// File: rtl/wave_shaper.sv
// wave_shaper: purely combinational phase-to-sample mapping.
//   phase  in  WIDTH : top WIDTH bits of the phase accumulator
//   mode   in  2     : waveform selector (mode_e)
//   duty   in  WIDTH : square threshold, output high while phase < duty
//   sample out WIDTH : resulting amplitude
module wave_shaper
    import wavegen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] phase,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] sample
);

    // Triangle: first half ramps 0,2,..,M-1; second half mirrors it by
    // bit inversion, giving M, M-2, .., 1.
    logic [WIDTH-1:0] tri_ramp;
    assign tri_ramp = {phase[WIDTH-2:0], 1'b0};

    always_comb begin
        sample = '0;
        case (mode)
            MODE_SQUARE:   sample = (phase < duty) ? '1 : '0;
            MODE_TRIANGLE: sample = phase[WIDTH-1] ? ~tri_ramp : tri_ramp;
            MODE_SAW_UP:   sample = phase;
            MODE_SAW_DOWN: sample = ~phase;
            default:       sample = '0;
        endcase
    end

endmodule

// File: rtl/param_wave_gen.sv
// param_wave_gen: phase-accumulator waveform generator with glitch-free
// reconfiguration.
//   clk_star    in  1     : clock, rising edge
//   reset       in  1     : asynchronous active-low reset
//   en          in  1     : advance enable; low holds acc and wave
//   cfg_valid   in  1     : configuration offer
//   cfg_ready   out 1     : no configuration pending
//   cfg_mode    in  2     : 0 square, 1 triangle, 2 saw up, 3 saw down
//   cfg_step    in  ACC_W : phase increment per enabled cycle
//   cfg_duty    in  WIDTH : square threshold
//   wave        out WIDTH : registered sample
//   wrap        out 1     : pulse on the first sample of a new period
//   active_mode out 2     : mode currently driving wave
//
// Config handshake: a transfer happens on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is simply !pend, so only one config can
// wait at a time and the source must hold its offer while cfg_ready is low.
// The waiting config becomes active only at a period boundary (carry), when
// the generator is stalled, or when the active step is zero (no boundary
// would ever come).
module param_wave_gen
    import wavegen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk_star,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [ACC_W-1:0] cfg_step,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic [WIDTH-1:0] wave,
    output logic             wrap,
    output logic [1:0]       active_mode
);

    typedef struct packed {
        mode_e            mode;
        logic [ACC_W-1:0] step;
        logic [WIDTH-1:0] duty;
    } cfg_t;

    localparam logic [ACC_W-1:0] DEF_STEP = ACC_W'(default_step(WIDTH, ACC_W));
    localparam logic [WIDTH-1:0] DEF_DUTY = WIDTH'(default_duty(WIDTH));
    localparam cfg_t DEF_CFG = '{mode: MODE_SQUARE, step: DEF_STEP, duty: DEF_DUTY};

    logic [ACC_W-1:0] acc;
    cfg_t             act_cfg;
    cfg_t             pend_cfg;
    logic             pend;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_next;
    logic             apply;
    logic             accept;
    cfg_t             cfg_next;
    logic [WIDTH-1:0] shaped;

    assign sum      = {1'b0, acc} + {1'b0, act_cfg.step};
    assign carry    = en & sum[ACC_W];
    assign acc_next = en ? sum[ACC_W-1:0] : acc;

    // pend is registered, so a config accepted on a carry edge waits for
    // the next qualifying edge.
    assign apply    = pend & (~en | carry | (act_cfg.step == '0));
    assign accept   = cfg_valid & ~pend;
    assign cfg_next = apply ? pend_cfg : act_cfg;

    // The sample uses the post-edge config so the wrap sample already shows
    // a newly applied waveform.
    wave_shaper #(.WIDTH(WIDTH)) u_shaper (
        .phase  (acc_next[ACC_W-1 -: WIDTH]),
        .mode   (cfg_next.mode),
        .duty   (cfg_next.duty),
        .sample (shaped)
    );

    always_ff @(posedge clk_star or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            wave     <= '0;
            wrap     <= 1'b0;
            act_cfg  <= DEF_CFG;
            pend_cfg <= DEF_CFG;
            pend     <= 1'b0;
        end else begin
            acc     <= acc_next;
            wrap    <= carry;
            act_cfg <= cfg_next;
            // Stalled: wave holds unless a config lands on the held phase.
            if (en || apply) begin
                wave <= shaped;
            end
            if (apply) begin
                pend <= 1'b0;
            end else if (accept) begin
                pend_cfg <= '{mode: mode_e'(cfg_mode), step: cfg_step, duty: cfg_duty};
                pend     <= 1'b1;
            end
        end
    end

    assign cfg_ready   = ~pend;
    assign active_mode = act_cfg.mode;

endmodule

// File: tb/tb_param_wave_gen.sv
module tb_param_wave_gen;

  logic        clk_star;
  logic        reset;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_step;
  logic [7:0]  cfg_duty;
  logic [7:0]  wave;
  logic        wrap;
  logic [1:0]  active_mode;

  int checks = 0;
  int errors = 0;

  param_wave_gen #(.WIDTH(8), .ACC_W(16)) dut (
    .clk_star    (clk_star),
    .reset       (reset),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_step    (cfg_step),
    .cfg_duty    (cfg_duty),
    .wave        (wave),
    .wrap        (wrap),
    .active_mode (active_mode)
  );

  // clock / reset block
  initial clk_star = 1'b0;
  always #5 clk_star = ~clk_star;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic        valid;
    logic [1:0]  mode;
    logic [15:0] step;
    logic [7:0]  duty;
    logic [7:0]  exp_wave;
    logic        exp_wrap;
    logic        exp_ready;
    logic [1:0]  exp_mode;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic e, logic v, logic [1:0] m, logic [15:0] s, logic [7:0] d,
                              logic [7:0] w, logic wr, logic rd, logic [1:0] am, string n);
    vec_t r;
    r.en = e; r.valid = v; r.mode = m; r.step = s; r.duty = d;
    r.exp_wave = w; r.exp_wrap = wr; r.exp_ready = rd; r.exp_mode = am; r.name = n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, need %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: one edge with given inputs, then check outputs 1 time unit later
  task automatic cycle(input logic e, input logic v, input logic [1:0] m, input logic [15:0] s,
                       input logic [7:0] d, input logic [7:0] w, input logic wr, input logic rd,
                       input logic [1:0] am, input string n);
    en = e; cfg_valid = v; cfg_mode = m; cfg_step = s; cfg_duty = d;
    @(posedge clk_star);
    #1;
    chk({n, ".wave"}, {8'h0, wave}, {8'h0, w});
    chk({n, ".wrap"}, {15'h0, wrap}, {15'h0, wr});
    chk({n, ".ready"}, {15'h0, cfg_ready}, {15'h0, rd});
    chk({n, ".mode"}, {14'h0, active_mode}, {14'h0, am});
  endtask

  task automatic run_vecs();
    foreach (vq[i])
      cycle(vq[i].en, vq[i].valid, vq[i].mode, vq[i].step, vq[i].duty,
            vq[i].exp_wave, vq[i].exp_wrap, vq[i].exp_ready, vq[i].exp_mode, vq[i].name);
    vq.delete();
  endtask

  task automatic check_reset_outputs(input string n);
    chk({n, ".wave"}, {8'h0, wave}, 16'h0);
    chk({n, ".wrap"}, {15'h0, wrap}, 16'h0);
    chk({n, ".ready"}, {15'h0, cfg_ready}, 16'h1);
    chk({n, ".mode"}, {14'h0, active_mode}, 16'h0);
  endtask

  function automatic logic [7:0] tri_ref(int ph);
    return (ph < 128) ? 8'(2 * ph) : 8'(255 - 2 * (ph - 128));
  endfunction

  initial begin
    reset = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_mode = 2'd0; cfg_step = 16'h0; cfg_duty = 8'h0;
    repeat (3) @(posedge clk_star);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // default square: step 0x0100, duty 0x80
    for (int k = 1; k <= 256; k++)
      cycle(1, 0, 0, 0, 0, ((k % 256) < 128) ? 8'hFF : 8'h00, k == 256, 1, 0, "dflt_sq");

    // load triangle while stalled, applied on the following edge
    vq.push_back(mk(0, 1, 1, 16'h0100, 8'h00, 8'hFF, 0, 0, 0, "tri_accept"));
    vq.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 1, "tri_apply"));
    run_vecs();

    for (int k = 1; k <= 256; k++)
      cycle(1, 0, 0, 0, 0, tri_ref(k % 256), k == 256, 1, 1, "tri_run");

    // back to square, run to p = 0x40
    vq.push_back(mk(0, 1, 0, 16'h0100, 8'h80, 8'h00, 0, 0, 1, "sq_accept"));
    vq.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 8'hFF, 0, 1, 0, "sq_apply"));
    run_vecs();
    for (int k = 1; k <= 'h40; k++)
      cycle(1, 0, 0, 0, 0, 8'hFF, 0, 1, 0, "sq_to_40");

    // offer SAW_UP mid-period: waits for the carry
    cycle(1, 1, 2, 16'h0400, 8'h33, 8'hFF, 0, 0, 0, "saw_offer");
    for (int p = 'h42; p <= 'hFF; p++)
      cycle(1, 0, 0, 0, 0, (p < 'h80) ? 8'hFF : 8'h00, 0, 0, 0, "sq_pending");

    vq.push_back(mk(1, 0, 0, 16'h0, 8'h0, 8'h00, 1, 1, 2, "saw_wrap"));
    vq.push_back(mk(1, 0, 0, 16'h0, 8'h0, 8'h04, 0, 1, 2, "saw_04"));
    vq.push_back(mk(1, 0, 0, 16'h0, 8'h0, 8'h08, 0, 1, 2, "saw_08"));
    vq.push_back(mk(1, 0, 0, 16'h0, 8'h0, 8'h0C, 0, 1, 2, "saw_0c"));
    // stalled apply: triangle of held phase 0x0C
    vq.push_back(mk(0, 1, 1, 16'h0400, 8'h00, 8'h0C, 0, 0, 2, "hold_accept"));
    vq.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 8'h18, 0, 1, 1, "hold_apply"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'h20, 0, 1, 1, "hold_resume"));
    // step 0: constant output, no wrap, pending config applies at once
    vq.push_back(mk(0, 1, 3, 16'h0000, 8'h00, 8'h20, 0, 0, 1, "z_accept"));
    vq.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 8'hEF, 0, 1, 3, "z_apply"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'hEF, 0, 1, 3, "z_const1"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'hEF, 0, 1, 3, "z_const2"));
    vq.push_back(mk(1, 1, 2, 16'h0100, 8'h00, 8'hEF, 0, 0, 3, "z_offer"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'h10, 0, 1, 2, "z_apply_en"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'h11, 0, 1, 2, "z_after"));
    // duty 0 square is constant 0
    vq.push_back(mk(0, 1, 0, 16'h0100, 8'h00, 8'h11, 0, 0, 2, "d0_accept"));
    vq.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, "d0_apply"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, "d0_run"));
    // second offer while pending is ignored
    vq.push_back(mk(1, 1, 3, 16'h0100, 8'h00, 8'h00, 0, 0, 0, "ign_first"));
    vq.push_back(mk(1, 1, 1, 16'h0200, 8'h00, 8'h00, 0, 0, 0, "ign_second"));
    vq.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 8'hEB, 0, 1, 3, "ign_apply"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'hEA, 0, 1, 3, "ign_step"));
    run_vecs();

    // accept on the carry edge: not applied until the next qualifying edge
    for (int p = 'h16; p <= 'hFF; p++)
      cycle(1, 0, 0, 0, 0, 8'(~p), 0, 1, 3, "sd_run");
    vq.push_back(mk(1, 1, 1, 16'h0100, 8'h00, 8'hFF, 1, 0, 3, "carry_accept"));
    vq.push_back(mk(1, 0, 0, 16'h0000, 8'h00, 8'hFE, 0, 0, 3, "carry_wait"));
    vq.push_back(mk(0, 0, 0, 16'h0000, 8'h00, 8'h02, 0, 1, 1, "carry_apply"));
    vq.push_back(mk(1, 1, 2, 16'h0400, 8'h00, 8'h04, 0, 0, 1, "rst_pend"));
    run_vecs();

    // asynchronous reset mid-period with a pending config
    cfg_valid = 1'b0;
    reset = 1'b0;
    #2;
    check_reset_outputs("rst_async");
    @(posedge clk_star);
    #1;
    check_reset_outputs("rst_held");
    reset = 1'b1;
    for (int k = 1; k <= 130; k++)
      cycle(1, 0, 0, 0, 0, (k < 128) ? 8'hFF : 8'h00, 0, 1, 0, "rst_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
